// File: rtl/unit_clause_eval_pipe_if.sv
// rtl/unit_clause_eval_pipe_if.sv - clause input and result output handshake bundle
interface unit_clause_eval_pipe_if #(
  parameter int CLAUSE_WIDTH = 8,
  parameter int CID_W        = 16
);
  localparam int IDX_W = $clog2(CLAUSE_WIDTH);

  logic                    in_valid;
  logic                    in_ready;
  logic [CID_W-1:0]        in_cid;
  logic [CLAUSE_WIDTH-1:0] in_mask;
  logic [CLAUSE_WIDTH-1:0] in_unassign;
  logic [CLAUSE_WIDTH-1:0] in_pole;
  logic [CLAUSE_WIDTH-1:0] in_value;
  logic                    out_valid;
  logic                    out_ready;
  logic [CID_W-1:0]        out_cid;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_value;
  logic                    out_conflict;

  modport master (
    output in_valid, in_cid, in_mask, in_unassign, in_pole, in_value, out_ready,
    input  in_ready, out_valid, out_cid, out_idx, out_value, out_conflict
  );

  modport slave (
    input  in_valid, in_cid, in_mask, in_unassign, in_pole, in_value, out_ready,
    output in_ready, out_valid, out_cid, out_idx, out_value, out_conflict
  );
endinterface

// File: rtl/unit_clause_eval_pipe.sv
// rtl/unit_clause_eval_pipe.sv - pipelined BCP clause classifier with unit/conflict result FIFO (optional UCE_STATS_EN counters)
module unit_clause_eval_pipe #(
  parameter int CLAUSE_WIDTH = 8,
  parameter int CID_W        = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  unit_clause_eval_pipe_if.slave       bus,
  output logic                         conflict_seen
`ifdef UCE_STATS_EN
  ,
  output logic [31:0]                  stat_units,
  output logic [31:0]                  stat_conflicts,
  output logic [31:0]                  stat_dropped
`endif
);
  localparam int IDX_W = $clog2(CLAUSE_WIDTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = CID_W + IDX_W + 2;
  localparam logic [CLAUSE_WIDTH-1:0] ONE_W = {{(CLAUSE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  // Classification of the clause on the input port
  logic [CLAUSE_WIDTH-1:0] true_vec;
  logic [CLAUSE_WIDTH-1:0] u_vec;
  logic                    sat;
  logic                    u_zero;
  logic                    u_one;
  logic                    is_unit;
  logic                    is_conf;
  logic [IDX_W-1:0]        u_idx;
  logic                    accept;

  assign true_vec = bus.in_mask & ~bus.in_unassign & (bus.in_value ^ bus.in_pole);
  assign u_vec    = bus.in_mask & bus.in_unassign;
  assign sat      = |true_vec;
  assign u_zero   = ~|u_vec;
  assign u_one    = ~u_zero && ((u_vec & (u_vec - ONE_W)) == '0);
  assign is_unit  = ~sat & u_one;
  assign is_conf  = ~sat & u_zero;
  assign accept   = bus.in_valid & bus.in_ready;

  // Locate the single unassigned slot; only meaningful when u_one is set
  always_comb begin
    u_idx = '0;
    for (int i = 0; i < CLAUSE_WIDTH; i++) begin
      if (u_vec[i]) u_idx = IDX_W'(i);
    end
  end

  // Stage 1: registered classification of the accepted clause
  logic             s1_valid;
  logic             s1_keep;
  logic             s1_conflict;
  logic [CID_W-1:0] s1_cid;
  logic [IDX_W-1:0] s1_idx;
  logic             s1_value;

  // Stage 1 register; dropped clauses still occupy the slot so in_ready stays conservative
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      s1_valid    <= 1'b0;
      s1_keep     <= 1'b0;
      s1_conflict <= 1'b0;
      s1_cid      <= '0;
      s1_idx      <= '0;
      s1_value    <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_keep     <= is_unit | is_conf;
        s1_conflict <= is_conf;
        s1_cid      <= bus.in_cid;
        s1_idx      <= is_unit ? u_idx : '0;
        s1_value    <= is_unit ? ~bus.in_pole[u_idx] : 1'b0;
      end
    end
  end

  // Result FIFO
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   occupancy;
  logic [ENT_W-1:0] head;

  assign push      = s1_valid & s1_keep;
  assign pop       = bus.out_valid & bus.out_ready;
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid};
  assign head      = mem[rd_ptr];

  assign bus.in_ready     = occupancy < DEPTH_C;
  assign bus.out_valid    = fifo_count != '0;
  assign bus.out_cid      = head[ENT_W-1 -: CID_W];
  assign bus.out_idx      = head[IDX_W+1 : 2];
  assign bus.out_value    = head[1];
  assign bus.out_conflict = head[0];

  // FIFO storage, pointers and occupancy; cleared so outputs read zero after reset/flush
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {s1_cid, s1_idx, s1_value, s1_conflict};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  // Sticky conflict flag, set when a conflict result enters the FIFO
  always_ff @(posedge clk) begin
    if (reset || flush)            conflict_seen <= 1'b0;
    else if (push && s1_conflict)  conflict_seen <= 1'b1;
  end

`ifdef UCE_STATS_EN
  // Saturating per-class counters of accepted clauses; survive flush
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_units     <= '0;
      stat_conflicts <= '0;
      stat_dropped   <= '0;
    end else if (accept && !flush) begin
      if (is_unit) begin
        if (stat_units != 32'hFFFF_FFFF) stat_units <= stat_units + 32'd1;
      end else if (is_conf) begin
        if (stat_conflicts != 32'hFFFF_FFFF) stat_conflicts <= stat_conflicts + 32'd1;
      end else begin
        if (stat_dropped != 32'hFFFF_FFFF) stat_dropped <= stat_dropped + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_unit_clause_eval_pipe.sv
// tb/tb_unit_clause_eval_pipe.sv - directed scoreboard bench for unit_clause_eval_pipe
module tb_unit_clause_eval_pipe;
  typedef struct packed {
    logic [15:0] cid;
    logic [2:0]  idx;
    logic        value;
    logic        conflict;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic conflict_seen;

  unit_clause_eval_pipe_if #(.CLAUSE_WIDTH(8), .CID_W(16)) bus ();

  unit_clause_eval_pipe #(.CLAUSE_WIDTH(8), .CID_W(16), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .bus           (bus),
    .conflict_seen (conflict_seen)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  int   sent;
  int   guard;
  int   pops_base;
  bit   acc;
  bit   ready_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference classifier: counts unassigned literals and looks for a true one
  function automatic bit model(input logic [15:0] cid, input logic [7:0] m, input logic [7:0] u,
                               input logic [7:0] p, input logic [7:0] v, output exp_t e);
    int nu;
    int last;
    bit satisfied;
    nu = 0; last = 0; satisfied = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        if (u[i]) begin nu++; last = i; end
        else if (v[i] != p[i]) satisfied = 1;
      end
    end
    e.cid = cid; e.idx = 3'd0; e.value = 1'b0; e.conflict = 1'b0;
    if (satisfied) return 1'b0;
    if (nu == 0) begin e.conflict = 1'b1; return 1'b1; end
    if (nu == 1) begin e.idx = 3'(last); e.value = ~p[last]; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic drive(input logic [15:0] cid, input logic [7:0] m, input logic [7:0] u,
                       input logic [7:0] p, input logic [7:0] v);
    bus.in_valid    = 1'b1;
    bus.in_cid      = cid;
    bus.in_mask     = m;
    bus.in_unassign = u;
    bus.in_pole     = p;
    bus.in_value    = v;
  endtask

  task automatic drive_unit(input int k);
    logic [7:0] u;
    logic [7:0] p;
    u = 8'(1 << (k % 8));
    p = (k % 2 == 1) ? u : 8'h00;
    drive(16'(k), 8'hFF, u, p, 8'h00);
  endtask

  // One clock: handshake decisions and scoreboard updates are made mid-cycle
  task automatic tick(output bit accepted);
    exp_t e;
    exp_t got;
    @(negedge clk);
    accepted = bus.in_valid && bus.in_ready && !flush;
    if (flush) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          check("sb_unexpected_output", 32'(bus.out_cid), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          got = '{bus.out_cid, bus.out_idx, bus.out_value, bus.out_conflict};
          check("sb_cid",      32'(got.cid),      32'(e.cid));
          check("sb_idx",      32'(got.idx),      32'(e.idx));
          check("sb_value",    32'(got.value),    32'(e.value));
          check("sb_conflict", 32'(got.conflict), 32'(e.conflict));
        end
      end
      if (accepted && model(bus.in_cid, bus.in_mask, bus.in_unassign, bus.in_pole, bus.in_value, e))
        sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_cid = '0; bus.in_mask = '0; bus.in_unassign = '0;
    bus.in_pole = '0; bus.in_value = '0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    check("rst_in_ready",      32'(bus.in_ready), 32'd1);
    check("rst_out_valid",     32'(bus.out_valid), 32'd0);
    check("rst_conflict_seen", 32'(conflict_seen), 32'd0);
    check("rst_out_cid",       32'(bus.out_cid), 32'd0);
    check("rst_out_idx",       32'(bus.out_idx), 32'd0);
    check("rst_out_conflict",  32'(bus.out_conflict), 32'd0);

    // Unit clause: slot 2 is the only unassigned literal
    drive(16'd5, 8'h0F, 8'h04, 8'h04, 8'h00);
    tick(acc);
    check("t1_accept", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
    check("t1_not_yet_valid", 32'(bus.out_valid), 32'd0);
    tick(acc);
    check("t1_out_valid", 32'(bus.out_valid), 32'd1);
    check("t1_cid",       32'(bus.out_cid), 32'd5);
    check("t1_idx",       32'(bus.out_idx), 32'd2);
    check("t1_value",     32'(bus.out_value), 32'd0);
    check("t1_conflict",  32'(bus.out_conflict), 32'd0);
    tick(acc);
    check("t1_stable_stall", 32'(bus.out_cid), 32'd5);
    bus.out_ready = 1'b1;
    tick(acc);
    check("t1_popped", 32'(bus.out_valid), 32'd0);

    // Conflict: both literals assigned false
    drive(16'd6, 8'h03, 8'h00, 8'h01, 8'h01);
    tick(acc);
    bus.in_valid = 1'b0;
    check("t2_seen_before_write", 32'(conflict_seen), 32'd0);
    tick(acc);
    check("t2_out_valid",     32'(bus.out_valid), 32'd1);
    check("t2_conflict",      32'(bus.out_conflict), 32'd1);
    check("t2_idx",           32'(bus.out_idx), 32'd0);
    check("t2_conflict_seen", 32'(conflict_seen), 32'd1);
    tick(acc);
    check("t2_seen_sticky", 32'(conflict_seen), 32'd1);

    // Satisfied and unresolved clauses produce nothing
    drive(16'd7, 8'h03, 8'h02, 8'h00, 8'h01);
    tick(acc);
    drive(16'd8, 8'h03, 8'h03, 8'h00, 8'h01);
    tick(acc);
    bus.in_valid = 1'b0;
    tick(acc);
    tick(acc);
    check("t3_no_output", 32'(bus.out_valid), 32'd0);
    check("t3_sb_empty",  32'(sb.size()), 32'd0);

    // Back-pressure: four results fill the FIFO with the consumer stalled
    bus.out_ready = 1'b0;
    sent = 0; guard = 0;
    while (sent < 4 && guard < 20) begin
      drive_unit(100 + sent);
      tick(acc);
      if (acc) sent++;
      guard++;
    end
    check("t4_accepted_4", 32'(sent), 32'd4);
    drive_unit(100 + sent);
    check("t4_in_ready_low", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      check("t4_no_accept_full", 32'(acc), 32'd0);
    end
    bus.out_ready = 1'b1;
    pops_base = pops;
    while (sent < 6 && guard < 40) begin
      drive_unit(100 + sent);
      tick(acc);
      if (acc) sent++;
      guard++;
    end
    bus.in_valid = 1'b0;
    while (sb.size() > 0 && guard < 60) begin
      tick(acc);
      guard++;
    end
    check("t4_sent_6",     32'(sent), 32'd6);
    check("t4_drain_done", 32'(sb.size()), 32'd0);
    check("t4_pop_count",  32'(pops - pops_base), 32'd6);

    // Flush with three results queued, one of them a conflict
    bus.out_ready = 1'b0;
    drive_unit(200);
    tick(acc);
    drive(16'd201, 8'h01, 8'h00, 8'h00, 8'h00);
    tick(acc);
    drive_unit(202);
    tick(acc);
    bus.in_valid = 1'b0;
    tick(acc);
    check("t5_queued",      32'(sb.size()), 32'd3);
    check("t5_seen_before", 32'(conflict_seen), 32'd1);
    flush = 1'b1;
    tick(acc);
    flush = 1'b0;
    check("t5_out_valid",     32'(bus.out_valid), 32'd0);
    check("t5_conflict_seen", 32'(conflict_seen), 32'd0);
    check("t5_in_ready",      32'(bus.in_ready), 32'd1);
    check("t5_out_cid_zero",  32'(bus.out_cid), 32'd0);
    tick(acc);
    check("t5_stays_empty", 32'(bus.out_valid), 32'd0);

    // Streaming: 16 unit clauses back to back with the consumer always ready
    bus.out_ready = 1'b1;
    ready_drop = 1'b0;
    pops_base = pops;
    for (int k = 0; k < 18; k++) begin
      if (k < 16) drive_unit(300 + k);
      else bus.in_valid = 1'b0;
      tick(acc);
      if (k < 16 && !acc) ready_drop = 1'b1;
    end
    check("t6_ready_never_dropped", 32'(ready_drop), 32'd0);
    check("t6_one_per_cycle",       32'(pops - pops_base), 32'd16);
    check("t6_sb_empty",            32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
